// File: rtl/ex_pkg.sv
// Shared op codes, FSM states and op-class helpers for the execute stage.
package ex_pkg;

    localparam int XLEN_DEF = 32;

    typedef enum logic [4:0] {
        OP_ADD    = 5'd0,
        OP_SUB    = 5'd1,
        OP_SLL    = 5'd2,
        OP_SLT    = 5'd3,
        OP_SLTU   = 5'd4,
        OP_XOR    = 5'd5,
        OP_SRL    = 5'd6,
        OP_SRA    = 5'd7,
        OP_OR     = 5'd8,
        OP_AND    = 5'd9,
        OP_MUL    = 5'd16,
        OP_MULH   = 5'd17,
        OP_MULHSU = 5'd18,
        OP_MULHU  = 5'd19,
        OP_DIV    = 5'd20,
        OP_DIVU   = 5'd21,
        OP_REM    = 5'd22,
        OP_REMU   = 5'd23
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL1,
        ST_DIV,
        ST_DONE
    } state_e;

    // codes 16..19
    function automatic logic is_mul(input logic [4:0] op);
        return op[4:2] == 3'b100;
    endfunction

    // codes 20..23
    function automatic logic is_div(input logic [4:0] op);
        return op[4:2] == 3'b101;
    endfunction

    // signed divide / remainder
    function automatic logic is_signed(input logic [4:0] op);
        return (op == OP_DIV) || (op == OP_REM);
    endfunction

endpackage

// File: rtl/iter_divider.sv
// Restoring radix-2 divider: one quotient bit per cycle on operand magnitudes,
// signs restored combinationally on the outputs.
module iter_divider #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            abort,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    input  logic            signed_op,
    output logic            done,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder
);
    localparam int CNT_W = $clog2(XLEN + 1);

    logic [XLEN-1:0]  quo_q, quo_d, rem_q, rem_d, dvs_q, dvs_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             active_q, active_d, neg_quo_q, neg_quo_d, neg_rem_q, neg_rem_d;
    logic [XLEN:0]    rem_shift, trial;

    function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

    // load on start, then shift/subtract one bit per cycle until the count runs out
    always_comb begin
        quo_d     = quo_q;
        rem_d     = rem_q;
        dvs_d     = dvs_q;
        cnt_d     = cnt_q;
        active_d  = active_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        rem_shift = {rem_q, quo_q[XLEN-1]};
        trial     = rem_shift - {1'b0, dvs_q};
        if (abort) begin
            active_d = 1'b0;
            cnt_d    = '0;
        end else if (start) begin
            neg_rem_d = signed_op && dividend[XLEN-1];
            neg_quo_d = signed_op && (dividend[XLEN-1] ^ divisor[XLEN-1]);
            quo_d     = mag(dividend, signed_op && dividend[XLEN-1]);
            dvs_d     = mag(divisor, signed_op && divisor[XLEN-1]);
            rem_d     = '0;
            cnt_d     = CNT_W'(XLEN);
            active_d  = 1'b1;
        end else if (active_q && cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
            if (!trial[XLEN]) begin
                rem_d = trial[XLEN-1:0];
                quo_d = {quo_q[XLEN-2:0], 1'b1};
            end else begin
                rem_d = rem_shift[XLEN-1:0];
                quo_d = {quo_q[XLEN-2:0], 1'b0};
            end
        end
    end

    // divider state registers
    always_ff @(posedge clk) begin
        if (reset) begin
            quo_q     <= '0;
            rem_q     <= '0;
            dvs_q     <= '0;
            cnt_q     <= '0;
            active_q  <= 1'b0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
        end else begin
            quo_q     <= quo_d;
            rem_q     <= rem_d;
            dvs_q     <= dvs_d;
            cnt_q     <= cnt_d;
            active_q  <= active_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
        end
    end

    assign done      = active_q && (cnt_q == '0);
    assign quotient  = mag(quo_q, neg_quo_q);
    assign remainder = mag(rem_q, neg_rem_q);

endmodule

// File: rtl/ex_muldiv_unit.sv
// Execute stage: operand forwarding, RV32I ALU, 2-stage multiply, iterative
// divide, and a registered result with valid/ready toward the memory stage.
//
//   state   | meaning
//   IDLE    | can accept; ALU and early-out divides complete here
//   MUL1    | product captured, selecting half into the output register
//   DIV     | divider iterating, counter running down from XLEN
//   DONE    | divider finished, waiting for a free output register
module ex_muldiv_unit #(
    parameter int XLEN    = ex_pkg::XLEN_DEF,
    parameter int NUM_FWD = 2,
    parameter int TAG_W   = 5
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [4:0]                       op,
    input  logic [XLEN-1:0]                  imm,
    input  logic [XLEN-1:0]                  rs1_data,
    input  logic [XLEN-1:0]                  rs2_data,
    input  logic                             alu_src,
    input  logic [$clog2(NUM_FWD+2)-1:0]     sel_op1,
    input  logic [$clog2(NUM_FWD+2)-1:0]     sel_op2,
    input  logic [NUM_FWD-1:0][XLEN-1:0]     fwd_data,
    input  logic [TAG_W-1:0]                 tag_in,
    input  logic                             flush,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [XLEN-1:0]                  result,
    output logic [XLEN-1:0]                  store_data,
    output logic [TAG_W-1:0]                 tag_out,
    output logic                             busy
);
    import ex_pkg::*;

    localparam int SH_W  = $clog2(XLEN);
    localparam int CNT_W = $clog2(XLEN + 1);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    op_e               op_in;
    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              out_valid_q, out_valid_d;
    logic [XLEN-1:0]   result_q, result_d, store_q, store_d, pend_sd_q, pend_sd_d;
    logic [TAG_W-1:0]  tag_q, tag_d, pend_tag_q, pend_tag_d;
    op_e               pend_op_q, pend_op_d;
    logic [2*XLEN-1:0] mul_prod_q, mul_prod_d, mul_a, mul_b, mul_prod;
    logic [XLEN-1:0]   op1, op2, op2_base, alu_res, div_quo, div_rem;
    logic [SH_W-1:0]   shamt;
    logic              accept, out_free, div_zero, div_early, div_start, div_abort, div_done;

    assign op_in    = op_e'(op);
    assign out_free = !out_valid_q || out_ready;
    assign in_ready = !reset && !flush && (state_q == ST_IDLE) && out_free;
    assign accept   = in_valid && in_ready;

    // operand forwarding muxes; unmapped selects give zero
    always_comb begin
        op2_base = alu_src ? rs2_data : imm;
        op1 = (sel_op1 == '0) ? rs1_data : '0;
        op2 = (sel_op2 == '0) ? op2_base : '0;
        for (int i = 0; i < NUM_FWD; i++) begin
            if (int'(sel_op1) == i + 1) op1 = fwd_data[i];
            if (int'(sel_op2) == i + 1) op2 = fwd_data[i];
        end
    end

    assign shamt     = op2[SH_W-1:0];
    assign div_zero  = (op2 == '0);
    assign div_early = div_zero || (is_signed(op) && op1 == MIN_NEG && op2 == '1);

    // single-cycle results, including the divide special cases
    always_comb begin
        alu_res = '0;
        case (op_in)
            OP_ADD:           alu_res = op1 + op2;
            OP_SUB:           alu_res = op1 - op2;
            OP_SLL:           alu_res = op1 << shamt;
            OP_SLT:           alu_res = XLEN'($signed(op1) < $signed(op2));
            OP_SLTU:          alu_res = XLEN'(op1 < op2);
            OP_XOR:           alu_res = op1 ^ op2;
            OP_SRL:           alu_res = op1 >> shamt;
            OP_SRA:           alu_res = $signed(op1) >>> shamt;
            OP_OR:            alu_res = op1 | op2;
            OP_AND:           alu_res = op1 & op2;
            OP_DIV, OP_DIVU:  alu_res = div_zero ? '1 : op1;
            OP_REM, OP_REMU:  alu_res = div_zero ? op1 : '0;
            default:          alu_res = '0;
        endcase
    end

    // sign-extend to 2*XLEN so one unsigned multiply covers all four variants
    always_comb begin
        mul_a    = {{XLEN{(op_in == OP_MULH || op_in == OP_MULHSU) && op1[XLEN-1]}}, op1};
        mul_b    = {{XLEN{(op_in == OP_MULH) && op2[XLEN-1]}}, op2};
        mul_prod = mul_a * mul_b;
    end

    iter_divider #(.XLEN(XLEN)) u_div (
        .clk       (clk),
        .reset     (reset),
        .start     (div_start),
        .abort     (div_abort),
        .dividend  (op1),
        .divisor   (op2),
        .signed_op (is_signed(op)),
        .done      (div_done),
        .quotient  (div_quo),
        .remainder (div_rem)
    );

    // next-state, output register loads and flush override
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q && !out_ready;
        result_d    = result_q;
        store_d     = store_q;
        tag_d       = tag_q;
        pend_op_d   = pend_op_q;
        pend_tag_d  = pend_tag_q;
        pend_sd_d   = pend_sd_q;
        mul_prod_d  = mul_prod_q;
        div_start   = 1'b0;
        div_abort   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    pend_op_d  = op_in;
                    pend_tag_d = tag_in;
                    pend_sd_d  = op2;
                    if (is_mul(op)) begin
                        state_d    = ST_MUL1;
                        mul_prod_d = mul_prod;
                    end else if (is_div(op) && !div_early) begin
                        state_d   = ST_DIV;
                        cnt_d     = CNT_W'(XLEN);
                        div_start = 1'b1;
                    end else begin
                        out_valid_d = 1'b1;
                        result_d    = alu_res;
                        store_d     = op2;
                        tag_d       = tag_in;
                    end
                end
            end
            ST_MUL1: begin
                if (out_free) begin
                    out_valid_d = 1'b1;
                    result_d    = (pend_op_q == OP_MUL) ? mul_prod_q[XLEN-1:0]
                                                        : mul_prod_q[2*XLEN-1:XLEN];
                    store_d     = pend_sd_q;
                    tag_d       = pend_tag_q;
                    state_d     = ST_IDLE;
                end
            end
            ST_DIV: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) state_d = ST_DONE;
            end
            ST_DONE: begin
                if (out_free && div_done) begin
                    out_valid_d = 1'b1;
                    result_d    = (pend_op_q == OP_REM || pend_op_q == OP_REMU) ? div_rem : div_quo;
                    store_d     = pend_sd_q;
                    tag_d       = pend_tag_q;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (flush) begin
            out_valid_d = 1'b0;
            state_d     = ST_IDLE;
            cnt_d       = '0;
            div_start   = 1'b0;
            div_abort   = 1'b1;
        end
    end

    // state and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            store_q     <= '0;
            tag_q       <= '0;
            pend_op_q   <= OP_ADD;
            pend_tag_q  <= '0;
            pend_sd_q   <= '0;
            mul_prod_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            store_q     <= store_d;
            tag_q       <= tag_d;
            pend_op_q   <= pend_op_d;
            pend_tag_q  <= pend_tag_d;
            pend_sd_q   <= pend_sd_d;
            mul_prod_q  <= mul_prod_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign result     = result_q;
    assign store_data = store_q;
    assign tag_out    = tag_q;
    assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed bench for ex_muldiv_unit with an arithmetic reference model and a
// scoreboard compared on every cycle out_valid is high.
module tb_ex_muldiv_unit;

    logic             clk = 1'b0;
    logic             reset, in_valid, in_ready, alu_src, flush, out_valid, out_ready, busy;
    logic [4:0]       op, tag_in, tag_out;
    logic [31:0]      imm, rs1_data, rs2_data, result, store_data;
    logic [1:0]       sel_op1, sel_op2;
    logic [1:0][31:0] fwd;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] res;
        logic [31:0] sd;
        logic [4:0]  tg;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic [4:0]  o;
        logic [31:0] r1, r2, im;
        logic        src;
        logic [1:0]  s1, s2;
        logic [31:0] lit;
    } vec_t;
    vec_t vecs[$];

    always #5 clk = ~clk;

    ex_muldiv_unit #(.XLEN(32), .NUM_FWD(2), .TAG_W(5)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .op         (op),
        .imm        (imm),
        .rs1_data   (rs1_data),
        .rs2_data   (rs2_data),
        .alu_src    (alu_src),
        .sel_op1    (sel_op1),
        .sel_op2    (sel_op2),
        .fwd_data   (fwd),
        .tag_in     (tag_in),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .result     (result),
        .store_data (store_data),
        .tag_out    (tag_out),
        .busy       (busy)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] resolve(input logic [1:0] s, input logic [31:0] base);
        case (s)
            2'd0:    return base;
            2'd1:    return fwd[0];
            2'd2:    return fwd[1];
            default: return 32'd0;
        endcase
    endfunction

    // RV32IM semantics in plain integer arithmetic
    function automatic logic [31:0] model(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb;
        longint unsigned ua, ub;
        logic [63:0]     p;
        logic            ovf;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ua  = longint'(a);
        ub  = longint'(b);
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (o)
            5'd0:  return a + b;
            5'd1:  return a - b;
            5'd2:  return a << b[4:0];
            5'd3:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            5'd4:  return (a < b) ? 32'd1 : 32'd0;
            5'd5:  return a ^ b;
            5'd6:  return a >> b[4:0];
            5'd7:  return 32'($signed(a) >>> b[4:0]);
            5'd8:  return a | b;
            5'd9:  return a & b;
            5'd16: begin p = ua * ub; return p[31:0];  end
            5'd17: begin p = sa * sb; return p[63:32]; end
            5'd18: begin p = sa * longint'(ub); return p[63:32]; end
            5'd19: begin p = ua * ub; return p[63:32]; end
            5'd20: return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'($signed(a) / $signed(b));
            5'd21: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            5'd22: return (b == 0) ? a : ovf ? 32'd0 : 32'($signed(a) % $signed(b));
            5'd23: return (b == 0) ? a : a % b;
            default: return 32'd0;
        endcase
    endfunction

    function automatic int exp_lat(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b);
        if (o >= 5'd16 && o <= 5'd19) return 2;
        if (o >= 5'd20 && o <= 5'd23) begin
            if (b == 0) return 1;
            if ((o == 5'd20 || o == 5'd22) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
            return 34;
        end
        return 1;
    endfunction

    // scoreboard compare on every cycle a result is presented
    always @(negedge clk) begin
        if (out_valid) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_out: out_valid high with result %h, nothing expected", result);
            end else begin
                check("cmp_result", result, sb[0].res);
                check("cmp_store", store_data, sb[0].sd);
                check("cmp_tag", 32'(tag_out), 32'(sb[0].tg));
                if (out_ready) void'(sb.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) step();
    endtask

    task automatic drive(input vec_t v, input logic [4:0] tg);
        op = v.o; rs1_data = v.r1; rs2_data = v.r2; imm = v.im;
        alu_src = v.src; sel_op1 = v.s1; sel_op2 = v.s2; tag_in = tg;
    endtask

    // offer one op, track it in the scoreboard, measure its latency
    task automatic issue(input vec_t v, input logic [4:0] tg);
        logic [31:0] a, b, e;
        int w, n;
        drive(v, tg);
        in_valid = 1'b1;
        #1;
        w = 0;
        while (!in_ready && w < 100) begin step(); w++; end
        check("issue_ready", in_ready, 1);
        a = resolve(v.s1, v.r1);
        b = resolve(v.s2, v.src ? v.r2 : v.im);
        e = model(v.o, a, b);
        check($sformatf("model_lit_op%0d", v.o), e, v.lit);
        sb.push_back('{e, b, tg});
        step();
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 100) begin
            check("busy_while_pending", busy, 1);
            check("in_ready_while_pending", in_ready, 0);
            step();
            n++;
        end
        check($sformatf("latency_op%0d", v.o), n, exp_lat(v.o, a, b));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; in_valid = 1'b0; op = '0; imm = '0; rs1_data = '0; rs2_data = '0;
        alu_src = 1'b0; sel_op1 = '0; sel_op2 = '0; tag_in = '0; flush = 1'b0; out_ready = 1'b1;
        fwd[0] = 32'h10; fwd[1] = 32'h100;

        vecs.push_back('{5'd0,  32'h0,        32'h0,        32'h5,    1'b0, 2'd1, 2'd0, 32'h15});
        vecs.push_back('{5'd17, 32'h8000_0000, 32'h8000_0000, 32'h0,  1'b1, 2'd0, 2'd0, 32'h4000_0000});
        vecs.push_back('{5'd20, 32'hFFFF_FFF9, 32'h2,        32'h0,    1'b1, 2'd0, 2'd0, 32'hFFFF_FFFD});
        vecs.push_back('{5'd22, 32'hFFFF_FFF9, 32'h2,        32'h0,    1'b1, 2'd0, 2'd0, 32'hFFFF_FFFF});
        vecs.push_back('{5'd21, 32'h1234,     32'h0,        32'h0,    1'b1, 2'd0, 2'd0, 32'hFFFF_FFFF});
        vecs.push_back('{5'd23, 32'h1234,     32'h0,        32'h0,    1'b1, 2'd0, 2'd0, 32'h1234});
        vecs.push_back('{5'd20, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,  1'b1, 2'd0, 2'd0, 32'h8000_0000});
        vecs.push_back('{5'd22, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,  1'b1, 2'd0, 2'd0, 32'h0});
        vecs.push_back('{5'd1,  32'h5,        32'h7,        32'h0,    1'b1, 2'd0, 2'd0, 32'hFFFF_FFFE});
        vecs.push_back('{5'd2,  32'h1,        32'h0,        32'h23,   1'b0, 2'd0, 2'd0, 32'h8});
        vecs.push_back('{5'd3,  32'hFFFF_FFFF, 32'h1,       32'h0,    1'b1, 2'd0, 2'd0, 32'h1});
        vecs.push_back('{5'd4,  32'hFFFF_FFFF, 32'h1,       32'h0,    1'b1, 2'd0, 2'd0, 32'h0});
        vecs.push_back('{5'd5,  32'hF0F0,     32'h0,        32'hFF00, 1'b0, 2'd0, 2'd0, 32'h0FF0});
        vecs.push_back('{5'd6,  32'h8000_0000, 32'h0,       32'h4,    1'b0, 2'd0, 2'd0, 32'h0800_0000});
        vecs.push_back('{5'd7,  32'h8000_0000, 32'h0,       32'h4,    1'b0, 2'd0, 2'd0, 32'hF800_0000});
        vecs.push_back('{5'd8,  32'hF000,     32'h0F0F,     32'h0,    1'b1, 2'd0, 2'd0, 32'hFF0F});
        vecs.push_back('{5'd9,  32'hF0F0,     32'h0FF0,     32'h0,    1'b1, 2'd0, 2'd0, 32'h00F0});
        vecs.push_back('{5'd16, 32'h7,        32'hFFFF_FFFD, 32'h0,   1'b1, 2'd0, 2'd0, 32'hFFFF_FFEB});
        vecs.push_back('{5'd18, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0,  1'b1, 2'd0, 2'd0, 32'hFFFF_FFFF});
        vecs.push_back('{5'd19, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0,  1'b1, 2'd0, 2'd0, 32'hFFFF_FFFE});
        vecs.push_back('{5'd21, 32'd100,      32'd7,        32'h0,    1'b1, 2'd0, 2'd0, 32'hE});
        vecs.push_back('{5'd23, 32'd100,      32'd7,        32'h0,    1'b1, 2'd0, 2'd0, 32'h2});
        vecs.push_back('{5'd20, 32'd7,        32'hFFFF_FFFE, 32'h0,   1'b1, 2'd0, 2'd0, 32'hFFFF_FFFD});
        vecs.push_back('{5'd22, 32'd7,        32'hFFFF_FFFE, 32'h0,   1'b1, 2'd0, 2'd0, 32'h1});
        vecs.push_back('{5'd12, 32'h5,        32'h3,        32'h0,    1'b1, 2'd0, 2'd0, 32'h0});
        vecs.push_back('{5'd0,  32'h0,        32'h0,        32'h5,    1'b0, 2'd2, 2'd3, 32'h100});
        vecs.push_back('{5'd0,  32'h1,        32'h0,        32'h0,    1'b0, 2'd0, 2'd1, 32'h11});
        vecs.push_back('{5'd17, 32'hFFFF_FFFE, 32'h3,       32'h0,    1'b1, 2'd0, 2'd0, 32'hFFFF_FFFF});
        vecs.push_back('{5'd1,  32'h55,       32'h0,        32'h1,    1'b0, 2'd3, 2'd0, 32'hFFFF_FFFF});
        vecs.push_back('{5'd20, 32'h0,        32'h5,        32'h0,    1'b1, 2'd0, 2'd0, 32'h0});

        // reset values
        repeat (3) step();
        check("rst_out_valid", out_valid, 0);
        check("rst_result", result, 0);
        check("rst_store_data", store_data, 0);
        check("rst_tag_out", 32'(tag_out), 0);
        check("rst_busy", busy, 0);
        check("rst_in_ready", in_ready, 0);
        reset = 1'b0;
        #1;
        check("in_ready_after_rst", in_ready, 1);
        step();

        // directed vectors
        foreach (vecs[i]) issue(vecs[i], 5'(i));
        idle(2);

        // back-to-back ALU ops, one per cycle
        for (int i = 0; i < 6; i++) begin
            vec_t v;
            logic [31:0] b;
            v = '{(i % 2 == 1) ? 5'd5 : 5'd0, 32'(i * 3), 32'h0, 32'(i + 100), 1'b0, 2'd0, 2'd0, 32'h0};
            drive(v, 5'(i + 8));
            in_valid = 1'b1;
            #1;
            check("b2b_in_ready", in_ready, 1);
            b = v.im;
            sb.push_back('{model(v.o, v.r1, b), b, 5'(i + 8)});
            step();
        end
        in_valid = 1'b0;
        idle(3);

        // backpressure: result must hold while out_ready is low
        out_ready = 1'b0;
        issue('{5'd0, 32'h20, 32'h0, 32'h3, 1'b0, 2'd0, 2'd0, 32'h23}, 5'd3);
        for (int c = 0; c < 3; c++) begin
            step();
            check("bp_in_ready", in_ready, 0);
            check("bp_out_valid", out_valid, 1);
            check("bp_result", result, 32'h23);
        end
        out_ready = 1'b1;
        drive('{5'd5, 32'hAAAA, 32'h0, 32'h5555, 1'b0, 2'd0, 2'd0, 32'h0}, 5'd4);
        in_valid = 1'b1;
        #1;
        check("bp_release_ready", in_ready, 1);
        sb.push_back('{32'hFFFF, 32'h5555, 5'd4});
        step();
        in_valid = 1'b0;
        check("bp_next_valid", out_valid, 1);
        idle(3);

        // flush at cycle 10 of a divide
        drive('{5'd20, 32'd1000, 32'd3, 32'h0, 1'b1, 2'd0, 2'd0, 32'h0}, 5'd7);
        in_valid = 1'b1;
        #1;
        check("flush_div_offer", in_ready, 1);
        step();
        in_valid = 1'b0;
        for (int c = 2; c < 10; c++) begin
            check("flush_div_busy", busy, 1);
            step();
        end
        flush = 1'b1;
        in_valid = 1'b1;
        op = 5'd0;
        #1;
        check("flush_masks_ready", in_ready, 0);
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        check("flush_busy_clear", busy, 0);
        check("flush_out_valid", out_valid, 0);
        for (int c = 0; c < 40; c++) begin
            step();
            if (c % 8 == 0) check("flush_no_result", out_valid, 0);
        end

        // flush while idle must block the offered op
        drive('{5'd0, 32'h1, 32'h0, 32'h1, 1'b0, 2'd0, 2'd0, 32'h0}, 5'd9);
        flush = 1'b1;
        in_valid = 1'b1;
        #1;
        check("flush_idle_ready", in_ready, 0);
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        check("flush_idle_no_accept", out_valid, 0);
        issue('{5'd0, 32'h40, 32'h0, 32'h2, 1'b0, 2'd0, 2'd0, 32'h42}, 5'd10);
        idle(2);

        // reset in the middle of a divide, then a clean divide
        drive('{5'd21, 32'd5000, 32'd9, 32'h0, 1'b1, 2'd0, 2'd0, 32'h0}, 5'd11);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (5) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_result", result, 0);
        issue('{5'd21, 32'd100, 32'd7, 32'h0, 1'b1, 2'd0, 2'd0, 32'hE}, 5'd12);
        issue('{5'd22, 32'hFFFF_FF9C, 32'd7, 32'h0, 1'b1, 2'd0, 2'd0, 32'hFFFF_FFFE}, 5'd13);
        idle(3);

        check("scoreboard_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
